// File: rtl/operand_capture.sv
// Input stage ahead of the ALU: synchronizes and debounces three buttons and latches the
// shared switch bus into operand A, operand B or the opcode on each debounced press.
module operand_capture #(
    parameter int unsigned NBITS           = 8,
    parameter int unsigned COD_OP          = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        pulsador,
    input  logic [NBITS-1:0]  entrada,
    output logic [NBITS-1:0]  o_a,
    output logic [NBITS-1:0]  o_b,
    output logic [COD_OP-1:0] o_op,
    output logic              o_op_strobe,
    output logic              o_ready
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [2:0]         btn_meta_q, btn_s_q;
    logic [NBITS-1:0]   data_meta_q, data_s_q;
    logic [2:0]         stable_q, stable_d;
    logic [2:0]         stable_dly_q;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic [2:0]         press;
    logic [2:0]         loaded_q;
    logic [NBITS-1:0]   a_q, b_q;
    logic [COD_OP-1:0]  op_q;
    logic               strobe_q;

    // Two-flop synchronizers for buttons and switch bus alike
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_q  <= '0;
            btn_s_q     <= '0;
            data_meta_q <= '0;
            data_s_q    <= '0;
        end else begin
            btn_meta_q  <= pulsador;
            btn_s_q     <= btn_meta_q;
            data_meta_q <= entrada;
            data_s_q    <= data_meta_q;
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (btn_s_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = btn_s_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q     <= '0;
            stable_dly_q <= '0;
            cnt_q        <= '0;
        end else begin
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = stable_q & ~stable_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            strobe_q <= 1'b0;
            loaded_q <= '0;
        end else begin
            if (press[0]) a_q <= data_s_q;
            if (press[1]) b_q <= data_s_q;
            if (press[2]) op_q <= data_s_q[COD_OP-1:0];
            strobe_q <= press[2];
            loaded_q <= loaded_q | press;
        end
    end

    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_op        = op_q;
    assign o_op_strobe = strobe_q;
    assign o_ready     = &loaded_q;

endmodule

// File: tb/tb_operand_capture.sv
// Scoreboard bench for operand_capture: a history-based reference model predicts outputs
// per clock; a monitor compares them against the DUT half a cycle away from stimulus changes.
module tb_operand_capture;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] pulsador = '0;
    logic [7:0] entrada = '0;
    logic [7:0] o_a, o_b;
    logic [5:0] o_op;
    logic       o_op_strobe, o_ready;

    operand_capture #(
        .NBITS(8),
        .COD_OP(6),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pulsador(pulsador),
        .entrada(entrada),
        .o_a(o_a),
        .o_b(o_b),
        .o_op(o_op),
        .o_op_strobe(o_op_strobe),
        .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic       strobe;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: raw input history since the last reset release
    logic [2:0] raw_p [0:16383];
    logic [7:0] raw_e [0:16383];
    int         k;
    int         run [3];
    bit   [2:0] level;
    bit   [2:0] pend;
    logic [7:0] pend_dat [3];
    logic [7:0] m_a, m_b;
    logic [5:0] m_op;
    logic       m_strobe;
    logic [2:0] m_loaded;

    function automatic exp_t model_out();
        exp_t x;
        x.a = m_a; x.b = m_b; x.op = m_op; x.strobe = m_strobe; x.ready = &m_loaded;
        return x;
    endfunction

    task automatic model_reset();
        k = 0;
        level = '0; pend = '0;
        m_a = '0; m_b = '0; m_op = '0; m_strobe = 1'b0; m_loaded = '0;
        for (int i = 0; i < 3; i++) begin
            run[i] = 0;
            pend_dat[i] = '0;
        end
    endtask

    task automatic model_edge(input logic [2:0] p, input logic [7:0] e);
        logic [2:0] old_p;
        bit bs;
        raw_p[k] = p;
        raw_e[k] = e;
        // Loads scheduled by presses accepted at the previous edge
        m_strobe = 1'b0;
        if (pend[0]) m_a = pend_dat[0];
        if (pend[1]) m_b = pend_dat[1];
        if (pend[2]) begin
            m_op = pend_dat[2][5:0];
            m_strobe = 1'b1;
        end
        m_loaded = m_loaded | pend;
        pend = '0;
        // Button as seen after two sync stages is the raw level from two edges back
        old_p = (k >= 2) ? raw_p[k-2] : 3'b000;
        for (int i = 0; i < 3; i++) begin
            bs = old_p[i];
            run[i] = (bs != level[i]) ? run[i] + 1 : 0;
            if (run[i] == D) begin
                level[i] = bs;
                run[i] = 0;
                if (bs) begin
                    pend[i] = 1'b1;
                    pend_dat[i] = (k >= 1) ? raw_e[k-1] : 8'h00;
                end
            end
        end
        if (k < 16383) k++;
    endtask

    function automatic exp_t dut_out();
        exp_t x;
        x.a = o_a; x.b = o_b; x.op = o_op; x.strobe = o_op_strobe; x.ready = o_ready;
        return x;
    endfunction

    task automatic compare(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got a=%h b=%h op=%h strobe=%b ready=%b want a=%h b=%h op=%h strobe=%b ready=%b",
                     name, $time, got.a, got.b, got.op, got.strobe, got.ready,
                     want.a, want.b, want.op, want.strobe, want.ready);
        end
    endtask

    // Monitor: every clock the DUT presents a new output tuple; check it against the queue
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare("cycle", dut_out(), exp_q.pop_front());
    end

    task automatic cyc(input logic r, input logic [2:0] p, input logic [7:0] e);
        logic was_running;
        @(negedge clk);
        was_running = rst_n;
        rst_n = r;
        pulsador = p;
        entrada = e;
        if (!r) begin
            model_reset();
            if (was_running) begin
                #1;
                compare("async_reset", dut_out(), model_out());
            end
        end
        @(posedge clk);
        if (rst_n) model_edge(p, e);
        exp_q.push_back(model_out());
    endtask

    task automatic hold(input int n, input logic [2:0] p, input logic [7:0] e);
        for (int i = 0; i < n; i++) cyc(1'b1, p, e);
    endtask

    initial begin
        logic [2:0] rp;
        logic [7:0] re;
        model_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b000, 8'h00);
        hold(2, 3'b000, 8'h00);
        // Load A, then B, then opcode
        hold(2, 3'b000, 8'h04);
        hold(10, 3'b001, 8'h04);
        hold(10, 3'b000, 8'h04);
        hold(2, 3'b000, 8'h05);
        hold(10, 3'b010, 8'h05);
        hold(10, 3'b000, 8'h05);
        hold(2, 3'b000, 8'h20);
        hold(10, 3'b100, 8'h20);
        hold(10, 3'b000, 8'h20);
        // Short glitch is rejected, exactly DEBOUNCE_CYCLES is accepted
        hold(3, 3'b000, 8'hFF);
        hold(3, 3'b001, 8'hFF);
        hold(10, 3'b000, 8'hFF);
        hold(4, 3'b001, 8'hFF);
        hold(10, 3'b000, 8'hFF);
        // Long hold yields a single load
        hold(3, 3'b000, 8'h22);
        hold(10, 3'b100, 8'h22);
        hold(40, 3'b100, 8'h24);
        hold(10, 3'b000, 8'h24);
        // Simultaneous A and B
        hold(3, 3'b000, 8'h09);
        hold(10, 3'b011, 8'h09);
        hold(10, 3'b000, 8'h09);
        // Reset in the middle of a press, button still held across release
        hold(3, 3'b000, 8'h33);
        hold(4, 3'b001, 8'h33);
        cyc(1'b0, 3'b001, 8'h33);
        cyc(1'b0, 3'b001, 8'h33);
        hold(12, 3'b001, 8'h33);
        hold(10, 3'b000, 8'h33);
        // Random bouncing buttons, drifting switches and occasional resets
        rp = '0;
        re = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(5) == 0) rp[i] = ~rp[i];
            if ($urandom_range(7) == 0) re = 8'($urandom);
            if ($urandom_range(599) == 0) begin
                cyc(1'b0, rp, re);
                cyc(1'b0, rp, re);
            end else begin
                cyc(1'b1, rp, re);
            end
        end
        hold(20, 3'b000, 8'h00);
        @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending entries want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
